// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among NREQ byte requesters.
// Optional feature macro UART_ARB_TIMEOUT_EN: WAIT timeout with sticky timeout_err output.
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic                    tx_newd,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_e;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES must be positive");
    end

    state_e          state_q;
    logic [IDXW-1:0] last_q;
    logic [IDXW-1:0] owner_q;
    logic [7:0]      data_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] done_q;
    logic            newd_q;

    logic            win_valid_d;
    logic [IDXW-1:0] win_idx_d;
    logic [IDXW-1:0] cand;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    // Scan from the highest offset down so the nearest requester after last_q wins.
    // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
    always_comb begin
        win_valid_d = 1'b0;
        win_idx_d   = '0;
        cand        = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDXW'((int'(last_q) + k) % NREQ);
            if (req[cand]) begin
                win_valid_d = 1'b1;
                win_idx_d   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= IDXW'(NREQ - 1);
            owner_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            newd_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking defaults make every pulse last one cycle; a later
            // non-blocking assignment in the same edge overrides the single bit it sets.
            ack_q  <= '0;
            done_q <= '0;
            newd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_valid_d) begin
                        data_q         <= req_data[8*win_idx_d +: 8];
                        owner_q        <= win_idx_d;
                        last_q         <= win_idx_d;
                        ack_q[win_idx_d] <= 1'b1;
                        state_q        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    newd_q  <= 1'b1;
                    state_q <= S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_WAIT: begin
                    if (tx_done) begin
                        done_q[owner_q] <= 1'b1;
                        state_q         <= S_IDLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        done_q[owner_q] <= 1'b1;
                        err_q           <= 1'b1;
                        state_q         <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign tx_newd = newd_q;
    assign tx_data = data_q;
    assign owner   = owner_q;
    assign busy    = (state_q != S_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter (NREQ=4) against a round-robin reference.
// With UART_ARB_TIMEOUT_EN defined, the WAIT timeout (TIMEOUT_CYCLES=20) is exercised too.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_newd;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [1:0]  owner;
`ifdef UART_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    logic outstanding;
    int   m_last;
    int   w;
    logic [3:0] m;

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .done     (done),
        .tx_newd  (tx_newd),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .owner    (owner)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec rule: first requester found scanning upward from last+1 with wrap-around.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int off = 1; off <= 4; off++)
            if (r[(last + off) % 4]) return (last + off) % 4;
        return 0;
    endfunction

    task automatic do_reset();
        rst     = 1'b0;
        req     = '0;
        tx_done = 1'b0;
        #1;
        check("rst_ack",     32'(ack), 0);
        check("rst_done",    32'(done), 0);
        check("rst_newd",    32'(tx_newd), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_owner",   32'(owner), 0);
`ifdef UART_ARB_TIMEOUT_EN
        check("rst_timeout_err", 32'(timeout_err), 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // One full transaction: ack after one cycle, tx_newd the next, tx_done after lat cycles.
    task automatic serve(input int idx, input logic [7:0] data, input int lat,
                         input logic drop, input logic [3:0] raise);
        int n;
        n = 0;
        while (ack === 4'b0 && n < 6) begin
            tick();
            n++;
        end
        check("ack_latency", 32'(n), 1);
        check("ack", 32'(ack), 32'(1) << idx);
        check("ack_busy", 32'(busy), 1);
        if (drop) req[idx] = 1'b0;
        tick();
        check("tx_newd", 32'(tx_newd), 1);
        check("tx_data", 32'(tx_data), 32'(data));
        check("owner", 32'(owner), 32'(idx));
        req = req | raise;
        repeat (lat) tick();
        check("hold_tx_data", 32'(tx_data), 32'(data));
        check("hold_owner", 32'(owner), 32'(idx));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("done", 32'(done), 32'(1) << idx);
        check("done_busy", 32'(busy), 0);
    endtask

    // Protocol watcher: one pulse per cycle, no launch while a frame is open, no orphan done.
    initial begin
        outstanding = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) outstanding = 1'b0;
            else begin
                check("one_pulse", 32'($countones({ack, done, tx_newd}) <= 1), 1);
                if (tx_newd) begin
                    check("newd_while_busy", 32'(outstanding), 0);
                    outstanding = 1'b1;
                end
                if (|done) begin
                    check("done_without_frame", 32'(outstanding), 1);
                    outstanding = 1'b0;
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        req      = '0;
        req_data = '0;
        tx_done  = 1'b0;

        // Single requester, long frame.
        do_reset();
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        serve(2, 8'hA5, 50, 1'b1, 4'b0000);

        // All four held: fair rotation 0,1,2,3,0.
        do_reset();
        req_data = 32'h44332211;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) serve(i % 4, 8'(8'h11 * ((i % 4) + 1)), 10, 1'b0, 4'b0000);
        req = 4'b0000;

        // Requester 3 holding; requester 1 arrives mid-frame and is served next.
        req = 4'b1000;
        serve(3, 8'h44, 10, 1'b0, 4'b0010);
        serve(1, 8'h22, 10, 1'b1, 4'b0000);
        serve(3, 8'h44, 10, 1'b1, 4'b0000);
        req = 4'b0000;

        // Reset in WAIT with owner 1 abandons the frame; priority restarts at 0.
        req = 4'b0010;
        tick();
        check("abort_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        repeat (4) tick();
        check("abort_owner", 32'(owner), 1);
        check("abort_busy", 32'(busy), 1);
        do_reset();
        req = 4'b0011;
        serve(0, 8'h11, 3, 1'b1, 4'b0000);
        serve(1, 8'h22, 3, 1'b1, 4'b0000);

        // tx_done in IDLE and in LAUNCH is ignored.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("idle_txdone_done", 32'(done), 0);
        check("idle_txdone_busy", 32'(busy), 0);
        check("idle_txdone_ack", 32'(ack), 0);
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        tick();
        check("launch_ack", 32'(ack), 32'h4);
        req = 4'b0000;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("launch_txdone_newd", 32'(tx_newd), 1);
        check("launch_txdone_done", 32'(done), 0);
        repeat (4) tick();
        check("launch_txdone_busy", 32'(busy), 1);
        check("launch_txdone_nodone", 32'(done), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("late_done", 32'(done), 32'h4);

        // Randomized traffic against the round-robin reference.
        do_reset();
        m_last = 3;
        for (int it = 0; it < 40; it++) begin
            m        = 4'($urandom_range(1, 15));
            req_data = $urandom;
            req      = m;
            w        = rr_pick(m, m_last);
            serve(w, req_data[8*w +: 8], int'($urandom_range(1, 8)), 1'b1, 4'($urandom_range(0, 15)));
            m_last = w;
            if ($urandom_range(0, 3) == 0) begin
                req = 4'b0000;
                repeat (2) tick();
                check("gap_ack", 32'(ack), 0);
                check("gap_busy", 32'(busy), 0);
            end
        end
        req = 4'b0000;

`ifdef UART_ARB_TIMEOUT_EN
        // No tx_done: timeout after 20 WAIT cycles raises sticky error.
        do_reset();
        req_data[7:0] = 8'h5A;
        req = 4'b0001;
        tick();
        check("to_ack", 32'(ack), 1);
        req = 4'b0000;
        tick();
        check("to_newd", 32'(tx_newd), 1);
        repeat (19) begin
            tick();
            check("to_no_early_done", 32'(done), 0);
        end
        check("to_no_early_err", 32'(timeout_err), 0);
        tick();
        check("to_done", 32'(done), 1);
        check("to_err", 32'(timeout_err), 1);
        check("to_busy", 32'(busy), 0);
        repeat (3) tick();
        check("to_err_sticky", 32'(timeout_err), 1);

        // tx_done on the limit cycle wins; no error.
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        check("lim_newd", 32'(tx_newd), 1);
        repeat (19) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("lim_done", 32'(done), 1);
        check("lim_err", 32'(timeout_err), 0);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter core among NREQ byte requesters.
- Sits between requesters (command logic, status reporters, loopback echo) and the transmitter's newd / data_in / tx_done handshake.
- Captures the winning requester's byte, launches exactly one frame, waits for completion, and reports back per requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 600000, clk cycles allowed between launch and tx_done; one frame at 450 MHz / 9600 baud is 468750 cycles. Used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- req  input  NREQ  per-requester request level; the requester holds it and its byte stable until ack.
- req_data  input  8*NREQ  flattened bytes; requester i uses bits [8*i+7:8*i].
- ack  output  NREQ  one-cycle pulse: byte of requester i captured.
- done  output  NREQ  one-cycle pulse: frame of requester i completed.
- tx_newd  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  byte to the transmitter; stable from the tx_newd cycle until tx_done.
- tx_done  input  1  one-cycle completion pulse from the transmitter.
- busy  output  1  high in any state other than IDLE.
- owner  output  $clog2(NREQ)  index of the current or last granted requester.

Behaviour:
Reset (rst=0):
- All outputs are 0, including ack, done, tx_newd, tx_data, busy and owner.
- State is IDLE.
- Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- Reset mid-frame abandons the transaction; no done pulse is issued.

State IDLE:
- If any req bit is set, select the first set bit scanning (last+1) mod NREQ upward with wrap-around.
- In the same edge: latch that requester's byte into tx_data, set owner, last = winner, pulse ack[winner], go to LAUNCH.
- If no req is set, stay in IDLE.

State LAUNCH:
- tx_newd=1 for exactly this cycle, then go to WAIT.

State WAIT:
- On tx_done=1: pulse done[owner] next cycle and go to IDLE.
- Arbitration resumes in the IDLE cycle that follows, so the minimum spacing between successive tx_newd pulses is 3 cycles after tx_done.

Latency:
- req rises in cycle 0 (in IDLE) -> ack in cycle 1 -> tx_newd in cycle 2.

Boundary rules:
- tx_done while in IDLE or LAUNCH is ignored.
- A req dropped before ack is never served.
- A req still high after ack is a new request, arbitrated fairly after the other requesters.
- A single requester holding req continuously is served back-to-back.
- req changes during LAUNCH or WAIT have no effect on tx_data or owner.
- Only one of ack / done / tx_newd bits is ever high in any cycle, and only for one cycle.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - Adds a counter that clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without tx_done, go to IDLE and pulse done[owner].
  - Also adds output timeout_err (1 bit), set sticky and cleared only by reset.
  - A tx_done arriving in the same cycle as the limit wins; no error is raised.
- Not defined:
  - WAIT holds indefinitely.
  - timeout_err port and counter are absent.

Test Plan:
1. Reset with req=4'b0000, then req[2]=1, data2=8'hA5 -> ack=4'b0100 in cycle 1, tx_newd with tx_data=8'hA5 in cycle 2, busy=1. Pulse tx_done 50 cycles later -> done=4'b0100 in the next cycle, busy=0.
2. All four req held high, tx_done returned 10 cycles after each tx_newd -> grant order 0,1,2,3,0; owner follows; no tx_newd while busy.
3. Only req[3] held high, then req[1] raised during its WAIT -> next grant is 1, then 3; no starvation.
4. Assert rst=0 during WAIT with owner=1 -> all outputs 0 immediately. After release, req[1] and req[0] high -> requester 0 granted first; no done for the aborted frame.
5. Pulse tx_done while in IDLE, and tx_done in the LAUNCH cycle -> no done, no state change; frame completes only on a later tx_done in WAIT.
6. With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20, no tx_done -> done[owner] and timeout_err=1 at 20 cycles into WAIT. Repeat with tx_done at exactly cycle 20 -> timeout_err stays 0.
